// File: rtl/adc_spi_capture.sv
// Multi-channel serial ADC capture. Generates cs_n/sclk from clk at a fixed
// sample rate, shifts one frame per channel in parallel, extracts the payload
// and optionally converts offset-binary to two's complement.
module adc_spi_capture #(
   parameter int CHANNELS      = 2,
   parameter int FRAME_BITS    = 16,
   parameter int LEAD_BITS     = 4,
   parameter int DATA_BITS     = 12,
   parameter int CLK_DIV       = 4,
   parameter int QUIET_CYC     = 8,
   parameter int SAMPLE_PERIOD = 2268,
   parameter int SIGNED_OUT    = 1
) (
   input  logic                          clk_i,
   input  logic                          reset_i,
   input  logic                          enable_i,
   input  logic [CHANNELS-1:0]           sdata_i,
   output logic                          cs_n_o,
   output logic                          sclk_o,
   output logic [CHANNELS*DATA_BITS-1:0] d_out_o,
   output logic                          valid_o,
   output logic                          busy_o
);

   localparam int TW      = $clog2(SAMPLE_PERIOD + 1);
   localparam int CNT_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam int BW      = $clog2(FRAME_BITS + 1);
   localparam int PL_MSB  = FRAME_BITS - 1 - LEAD_BITS;

   localparam logic [TW-1:0] TMR_LAST   = TW'(SAMPLE_PERIOD - 1);
   localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] QUIET_LAST = CW'(QUIET_CYC - 1);
   localparam logic [BW-1:0] BIT_LAST   = BW'(FRAME_BITS - 1);

   typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, QUIET} state_t;

   state_t                                state_q, state_d;
   logic [TW-1:0]                         timer_q, timer_d;
   logic                                  tick_q, tick_d;
   logic [CW-1:0]                         cnt_q, cnt_d;
   logic [BW-1:0]                         bit_q, bit_d;
   logic [CHANNELS-1:0][FRAME_BITS-1:0]   sh_q, sh_d;
   logic                                  cs_n_q, cs_n_d;
   logic                                  sclk_q, sclk_d;
   logic [CHANNELS*DATA_BITS-1:0]         dout_q, dout_d;
   logic                                  valid_q, valid_d;
   logic                                  busy_q, busy_d;
   logic [DATA_BITS-1:0]                  pl;
   logic                                  div_done;

   // Sample timer: free-runs while enabled, the wrap is registered as the tick
   // so the frame starts one cycle after the wrap.
   always_comb begin
      timer_d = '0;
      tick_d  = 1'b0;
      if (enable_i) begin
         tick_d  = (timer_q == TMR_LAST);
         timer_d = (timer_q == TMR_LAST) ? '0 : timer_q + 1'b1;
      end
   end

   // Frame sequencer: next state, serial clock, shift registers and outputs.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      cs_n_d   = cs_n_q;
      sclk_d   = sclk_q;
      dout_d   = dout_q;
      valid_d  = 1'b0;
      busy_d   = busy_q;
      pl       = '0;
      div_done = (cnt_q == DIV_LAST);
      case (state_q)
         IDLE: begin
            cs_n_d = 1'b1;
            sclk_d = 1'b1;
            if (tick_q) begin
               state_d = SETUP;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               cnt_d   = '0;
               bit_d   = '0;
            end
         end
         SETUP: begin
            if (div_done) begin
               sclk_d  = 1'b0;
               cnt_d   = '0;
               state_d = SHIFT;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         SHIFT: begin
            if (div_done) begin
               cnt_d  = '0;
               sclk_d = ~sclk_q;
               // data is captured on the edge that drives sclk high
               if (!sclk_q) begin
                  for (int c = 0; c < CHANNELS; c++)
                     sh_d[c] = {sh_q[c][FRAME_BITS-2:0], sdata_i[c]};
                  bit_d = bit_q + 1'b1;
                  if (bit_q == BIT_LAST) state_d = HOLD;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         HOLD: begin
            if (div_done) begin
               cs_n_d  = 1'b1;
               valid_d = 1'b1;
               cnt_d   = '0;
               state_d = QUIET;
               for (int c = 0; c < CHANNELS; c++) begin
                  pl = sh_q[c][PL_MSB -: DATA_BITS];
                  if (SIGNED_OUT != 0) pl[DATA_BITS-1] = ~pl[DATA_BITS-1];
                  dout_d[c*DATA_BITS +: DATA_BITS] = pl;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         QUIET: begin
            if (cnt_q == QUIET_LAST) begin
               state_d = IDLE;
               busy_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset drops any partial frame immediately.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         timer_q <= '0;
         tick_q  <= 1'b0;
         cnt_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         cs_n_q  <= 1'b1;
         sclk_q  <= 1'b1;
         dout_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         tick_q  <= tick_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         cs_n_q  <= cs_n_d;
         sclk_q  <= sclk_d;
         dout_q  <= dout_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign cs_n_o  = cs_n_q;
   assign sclk_o  = sclk_q;
   assign d_out_o = dout_q;
   assign valid_o = valid_q;
   assign busy_o  = busy_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: two instances (unsigned / signed output), each
// fed by a behavioural ADC that serves a frame word MSB first on sclk rises.
module tb_adc_spi_capture;

   localparam int SP   = 200;
   localparam int F    = 16;
   localparam int LEAD = 4;
   localparam int DATA = 12;

   logic clk = 1'b0;
   logic run_clk = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   logic mon_on = 1'b0;
   int   cyc = 0;

   wire [1:0]  cs_n_w, sclk_w, valid_w, busy_w;
   wire [23:0] dout_w [2];

   logic [15:0] frame [2][2] = '{'{16'h0ABC, 16'h0123}, '{16'h0ABC, 16'h0123}};

   int checks = 0;
   int errors = 0;

   always #5 if (run_clk) clk = ~clk;
   always @(posedge clk) cyc++;

   for (genvar g = 0; g < 2; g++) begin : gdut
      logic [1:0] sd;
      int   adc_cnt = 0;
      logic cs_prev = 1'b1;

      adc_spi_capture #(.SAMPLE_PERIOD(SP), .SIGNED_OUT(g)) u_dut (
         .clk_i    (clk),
         .reset_i  (reset),
         .enable_i (enable),
         .sdata_i  (sd),
         .cs_n_o   (cs_n_w[g]),
         .sclk_o   (sclk_w[g]),
         .d_out_o  (dout_w[g]),
         .valid_o  (valid_w[g]),
         .busy_o   (busy_w[g])
      );

      // ADC: counts sclk rises since cs_n fell, presents the next frame bit
      always @(posedge sclk_w[g] or cs_n_w[g]) begin
         if (cs_n_w[g])    adc_cnt = 0;
         else if (cs_prev) adc_cnt = 0;
         else              adc_cnt++;
         cs_prev = cs_n_w[g];
      end

      always_comb
         for (int c = 0; c < 2; c++)
            sd[c] = (adc_cnt < F) ? frame[g][c][F-1-adc_cnt] : 1'b0;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, act, exp);
      end
   endtask

   // expected word straight from the frame: payload field, optional MSB flip
   function automatic logic [23:0] model(input logic [15:0] f0, input logic [15:0] f1, input int sgn);
      int v0, v1;
      v0 = (int'(f0) >> (F - LEAD - DATA)) % (1 << DATA);
      v1 = (int'(f1) >> (F - LEAD - DATA)) % (1 << DATA);
      if (sgn != 0) begin
         v0 = v0 ^ (1 << (DATA - 1));
         v1 = v1 ^ (1 << (DATA - 1));
      end
      return {v1[11:0], v0[11:0]};
   endfunction

   // monitor state
   logic [23:0] expq [2][$];
   int   exp_fall [2];
   int   fall_n [2], rises [2], last_rise [2], sfall_n [2], busy_rise [2];
   int   nvalid [2] = '{0, 0};
   int   nfall [2]  = '{0, 0};
   logic prev_cs [2]    = '{1'b1, 1'b1};
   logic prev_sclk [2]  = '{1'b1, 1'b1};
   logic prev_busy [2]  = '{1'b0, 1'b0};
   logic prev_valid [2] = '{1'b0, 1'b0};
   logic [23:0] last_dout [2]  = '{24'h0, 24'h0};
   logic [23:0] first_dout [2] = '{24'h0, 24'h0};
   int   idle_viol = 0;
   int   hold_viol = 0;

   always @(negedge clk) begin
      if (mon_on) begin
         for (int g = 0; g < 2; g++) begin
            if (reset) begin
               chk("rst_cs", cs_n_w[g], 1);
               chk("rst_dout", dout_w[g], 0);
               expq[g].delete();
               prev_cs[g] = 1'b1; prev_sclk[g] = 1'b1;
               prev_busy[g] = 1'b0; prev_valid[g] = 1'b0;
               last_dout[g] = '0;
            end else begin
               if (prev_cs[g] && !cs_n_w[g]) begin
                  chk("cs_fall_at", cyc, exp_fall[g]);
                  exp_fall[g] += SP;
                  nfall[g]++;
                  fall_n[g] = cyc; rises[g] = 0; sfall_n[g] = -1;
                  expq[g].push_back(model(frame[g][0], frame[g][1], g));
               end
               if (!cs_n_w[g] && prev_sclk[g] && !sclk_w[g] && sfall_n[g] < 0) sfall_n[g] = cyc;
               if (!cs_n_w[g] && !prev_sclk[g] && sclk_w[g]) begin
                  rises[g]++;
                  last_rise[g] = cyc;
               end
               if (cs_n_w[g] && !sclk_w[g]) idle_viol++;
               if (!prev_busy[g] && busy_w[g]) busy_rise[g] = cyc;
               if (prev_busy[g] && !busy_w[g]) chk("busy_len", cyc - busy_rise[g], 140);
               if (valid_w[g]) begin
                  chk("valid_1cyc", prev_valid[g], 0);
                  chk("valid_expected", expq[g].size(), 1);
                  if (expq[g].size() > 0) chk("dout", dout_w[g], expq[g].pop_front());
                  chk("valid_lat", cyc - fall_n[g], 132);
                  chk("cs_at_valid", cs_n_w[g], 1);
                  chk("sclk_rises", rises[g], 16);
                  chk("last_rise", last_rise[g] - fall_n[g], 128);
                  chk("sclk_fall", sfall_n[g] - fall_n[g], 4);
                  if (nvalid[g] == 0) first_dout[g] = dout_w[g];
                  nvalid[g]++;
                  last_dout[g] = dout_w[g];
                  frame[g][0] = 16'($urandom());
                  frame[g][1] = 16'($urandom());
               end else if (dout_w[g] != last_dout[g]) begin
                  hold_viol++;
               end
               prev_cs[g]    = cs_n_w[g];
               prev_sclk[g]  = sclk_w[g];
               prev_busy[g]  = busy_w[g];
               prev_valid[g] = valid_w[g];
            end
         end
      end
   end

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic set_exp(input int v);
      exp_fall[0] = v;
      exp_fall[1] = v;
   endtask

   task automatic wait_falls(input int target);
      int b = 0;
      while (nfall[0] < target && b < 1000) begin
         step(1);
         b++;
      end
      chk("wait_fall", nfall[0] >= target, 1);
   endtask

   task automatic wait_cyc(input int t);
      int b = 0;
      while (cyc < t && b < 2000) begin
         step(1);
         b++;
      end
   endtask

   initial begin
      set_exp(-1);
      // asynchronous reset with the clock stopped
      #2 reset = 1'b1;
      #1;
      for (int g = 0; g < 2; g++) begin
         chk("por_cs_n", cs_n_w[g], 1);
         chk("por_sclk", sclk_w[g], 1);
         chk("por_dout", dout_w[g], 0);
         chk("por_valid", valid_w[g], 0);
         chk("por_busy", busy_w[g], 0);
      end
      run_clk = 1'b1;
      mon_on  = 1'b1;
      step(3);
      reset = 1'b0;
      step(2);

      // free-running frames, first one with fixed frame words
      enable = 1'b1;
      set_exp(cyc + 1 + SP);
      wait_falls(3);
      // drop enable mid-frame: this frame still completes
      wait_cyc(fall_n[0] + 49);
      enable = 1'b0;
      set_exp(-1);
      step(400);
      chk("nvalid_a0", nvalid[0], 3);
      chk("nvalid_a1", nvalid[1], 3);
      chk("dir_unsigned", first_dout[0], 24'h123ABC);
      chk("dir_signed", first_dout[1], 24'h9232BC);

      // reset in the middle of a frame: no valid for it
      enable = 1'b1;
      set_exp(cyc + 1 + SP);
      wait_falls(4);
      wait_cyc(fall_n[0] + 59);
      reset = 1'b1;
      set_exp(-1);
      step(3);
      reset = 1'b0;
      set_exp(cyc + 1 + SP);
      wait_falls(6);
      enable = 1'b0;
      set_exp(-1);
      step(400);

      chk("nvalid_b0", nvalid[0], 5);
      chk("nvalid_b1", nvalid[1], 5);
      chk("nfall0", nfall[0], 6);
      chk("nfall1", nfall[1], 6);
      chk("sclk_idle", idle_viol, 0);
      chk("dout_hold", hold_viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
